sd_cpu_reg_bridge: RTL and testbench
====================================

Name: sd_cpu_reg_bridge

Overview:
- Parametrised CPU-to-register-file bridge for the SD host controller register block.
- Decodes CPU accesses into per-register write enables with byte strobes, and muxes a flat register read bus back to the CPU.
- Uses a registered four-phase req/ack handshake with an error response for unmapped, misaligned or read-only-write accesses.
- Sits between the CPU bus agent and the SD host register file.

Parameters:
- DATA_W, 32: CPU and register data width; multiple of 8, minimum 16.
- ADDR_W, 12: CPU byte-address width.
- NUM_REGS, 32: number of DATA_W-wide register slots in the window.
- BASE_ADDR, 12'h000: byte address of slot 0.
- RO_MASK, {NUM_REGS{1'b0}}: bit i=1 marks slot i read-only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  request; held high until cpu_ack seen
- cpu_wr  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  ADDR_W  byte address
- cpu_wr_data  in  DATA_W  write data
- cpu_be  in  DATA_W/8  byte enables for writes
- cpu_rd_data  out  DATA_W  read data, valid while cpu_ack=1
- cpu_ack  out  1  transfer complete
- cpu_err  out  1  error status, valid while cpu_ack=1
- reg_wr_en  out  NUM_REGS  one-hot write pulse
- reg_be  out  DATA_W/8  byte strobes accompanying reg_wr_en
- reg_wr_data  out  DATA_W  write data to register file
- reg_rd_strobe  out  NUM_REGS  one-hot read pulse, for read side effects
- reg_rd_data  in  NUM_REGS*DATA_W  flat read bus; slot i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async, rst_n=0): state=IDLE. cpu_ack, cpu_err, cpu_rd_data, reg_wr_en, reg_be, reg_wr_data and reg_rd_strobe are all 0. Capture registers are cleared.
- Decode:
  - off = cpu_addr - BASE_ADDR; idx = off >> log2(DATA_W/8).
  - Mapped when cpu_addr >= BASE_ADDR, idx < NUM_REGS, and the low log2(DATA_W/8) bits of off are 0.
  - Otherwise the access is unmapped.
- FSM states: IDLE, EXEC, RESP.
- IDLE: when cpu_req=1, capture cpu_wr, cpu_addr, cpu_wr_data and cpu_be, then go to EXEC.
- EXEC (exactly 1 cycle), write:
  - Mapped, not RO, cpu_be≠0: reg_wr_en[idx]=1, with reg_be and reg_wr_data = captured values.
  - RO slot or unmapped: no enable; err=1.
  - cpu_be=0: no enable; err=0.
- EXEC (exactly 1 cycle), read:
  - Mapped: reg_rd_strobe[idx]=1, and slot idx is registered into cpu_rd_data at the end of EXEC.
  - Unmapped: cpu_rd_data=0, err=1.
- After EXEC, go to RESP.
- RESP: cpu_ack=1 and cpu_err holds. Stay in RESP while cpu_req=1. When cpu_req=0, go to IDLE with cpu_ack=0 and cpu_err=0 on the next cycle. cpu_rd_data keeps its last value.
- Latency: if cpu_req is sampled high at edge N, the reg_* pulse is high in cycle N..N+1 and cpu_ack rises at edge N+2.
- Pulses: reg_wr_en and reg_rd_strobe are exactly 1 cycle, at most one bit set, and never both in the same cycle.
- cpu_req dropped during EXEC: the access still completes. RESP then lasts 1 cycle, with ack high for 1 cycle, then IDLE.
- Back-to-back: a new request is accepted only from IDLE, so the minimum cycle is 3 clocks per transfer plus the release cycle.
- Inputs other than cpu_req are ignored outside IDLE.
- Reset mid-transfer: pending writes are dropped and outputs clear immediately. If cpu_req is still high after release, it is treated as a new transfer.
- reg_rd_data is sampled only in EXEC; it may change at any other time.

Decomposition:
- Package sd_reg_pkg holds:
  - FSM state enum (IDLE/EXEC/RESP).
  - SD host register offset constants: 004h, 006h, 008h, 00Ah, 00Ch, 00Eh, 010h, 012h, 024h, 02Ah, 030h, 032h, 054h.
  - Default RO_MASK for 024h and 030h.
- One sub-module, sd_reg_addr_decode (combinational): addr -> idx, mapped, misaligned, ro.

Test Plan:
- Reset: rst_n low mid-EXEC of a write to 0x010 -> reg_wr_en stays 0, all outputs are 0 within the same cycle, state=IDLE.
- Write: BASE=0, DATA_W=32, write 0x010 data 0xDEADBEEF be=4'b0011 -> reg_wr_en[4] pulses 1 cycle with reg_be=0011 and data=DEADBEEF. Ack at req+2, err=0; ack drops 1 cycle after req drops.
- Read: reg_rd_data slot 0x0C=0x12345678, read 0x030 -> reg_rd_strobe[12] pulses once, cpu_rd_data=0x12345678, ack=1, err=0.
- Errors:
  - Read 0x082 (misaligned) -> err=1, rd_data=0.
  - Write 0x200 (NUM_REGS=32, unmapped) -> err=1, no reg_wr_en.
  - Write slot in RO_MASK -> err=1, no enable.
- Handshake edge cases:
  - cpu_req dropped in EXEC -> ack high exactly 1 cycle.
  - cpu_req held 10 cycles -> ack held 10 cycles, and only one reg_wr_en pulse is issued.
- Parametrisation: DATA_W=16, NUM_REGS=64, BASE=0x100; write 0x10E -> reg_wr_en[7] pulses, reg_be width 2.

Source files
------------

// File: rtl/sd_reg_pkg.sv
// Shared types and SD host register map constants for the CPU register bridge.
// Slot numbers are derived from the byte offsets for a 32-bit register window.
package sd_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } sd_state_e;

    localparam logic [11:0] SD_OFF_BLK_SIZE      = 12'h004;
    localparam logic [11:0] SD_OFF_BLK_COUNT     = 12'h006;
    localparam logic [11:0] SD_OFF_ARG_LO        = 12'h008;
    localparam logic [11:0] SD_OFF_ARG_HI        = 12'h00A;
    localparam logic [11:0] SD_OFF_XFER_MODE     = 12'h00C;
    localparam logic [11:0] SD_OFF_COMMAND       = 12'h00E;
    localparam logic [11:0] SD_OFF_RESP0         = 12'h010;
    localparam logic [11:0] SD_OFF_RESP1         = 12'h012;
    localparam logic [11:0] SD_OFF_PRESENT_STATE = 12'h024;
    localparam logic [11:0] SD_OFF_BLK_GAP_CTRL  = 12'h02A;
    localparam logic [11:0] SD_OFF_NORM_INT_STAT = 12'h030;
    localparam logic [11:0] SD_OFF_ERR_INT_STAT  = 12'h032;
    localparam logic [11:0] SD_OFF_ADMA_ERR_STAT = 12'h054;

    function automatic int sd_slot_of(input logic [11:0] off, input int data_w);
        return int'(off) / (data_w / 8);
    endfunction

    // Present-state and normal-interrupt-status slots are never CPU-writable.
    localparam logic [31:0] SD_RO_MASK_DEFAULT =
        (32'd1 << sd_slot_of(SD_OFF_PRESENT_STATE, 32)) |
        (32'd1 << sd_slot_of(SD_OFF_NORM_INT_STAT, 32));

endpackage

// File: rtl/sd_reg_addr_decode.sv
// Combinational byte-address to register-slot decode for the SD register window.
// Misaligned and out-of-window addresses are reported as not mapped.
module sd_reg_addr_decode
    import sd_reg_pkg::*;
#(
    parameter int                  ADDR_W    = 12,
    parameter int                  DATA_W    = 32,
    parameter int                  NUM_REGS  = 32,
    parameter int                  IDX_W     = 5,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              mapped,
    output logic              misaligned,
    output logic              ro
);
    localparam int                BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] word_s;
    logic              below_s;
    logic              in_range_s;

    assign below_s    = (addr < BASE_ADDR);
    assign off_s      = addr - BASE_ADDR;
    assign word_s     = off_s >> BYTE_SHIFT;
    // Range test uses the full word index so out-of-window addresses never alias.
    assign in_range_s = ({1'b0, word_s} < NUM_REGS_L);
    assign misaligned = |off_s[BYTE_SHIFT-1:0];
    assign mapped     = !below_s && in_range_s && !misaligned;
    assign idx        = word_s[IDX_W-1:0];
    assign ro         = mapped && RO_MASK[idx];

endmodule

// File: rtl/sd_cpu_reg_bridge.sv
// CPU-to-register-file bridge: decodes req/ack accesses into one-cycle register
// write/read pulses and returns read data with an error status.
module sd_cpu_reg_bridge
    import sd_reg_pkg::*;
#(
    parameter int                  DATA_W    = 32,
    parameter int                  ADDR_W    = 12,
    parameter int                  NUM_REGS  = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_req,
    input  logic                       cpu_wr,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wr_data,
    input  logic [DATA_W/8-1:0]        cpu_be,
    output logic [DATA_W-1:0]          cpu_rd_data,
    output logic                       cpu_ack,
    output logic                       cpu_err,
    output logic [NUM_REGS-1:0]        reg_wr_en,
    output logic [DATA_W/8-1:0]        reg_be,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic [NUM_REGS-1:0]        reg_rd_strobe,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rd_data
);
    localparam int                  IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [NUM_REGS-1:0] SLOT0_L = NUM_REGS'(1'b1);

    sd_state_e         state_r;
    logic              is_wr_r;
    logic              err_r;
    logic              mapped_r;
    logic [IDX_W-1:0]  idx_r;

    logic [IDX_W-1:0]    dec_idx_s;
    logic                dec_mapped_s;
    logic                dec_misaligned_s;
    logic                dec_ro_s;
    logic                bad_addr_s;
    logic [NUM_REGS-1:0] dec_onehot_s;

    sd_reg_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR),
        .RO_MASK   (RO_MASK)
    ) u_decode (
        .addr       (cpu_addr),
        .idx        (dec_idx_s),
        .mapped     (dec_mapped_s),
        .misaligned (dec_misaligned_s),
        .ro         (dec_ro_s)
    );

    assign bad_addr_s   = !dec_mapped_s || dec_misaligned_s;
    assign dec_onehot_s = SLOT0_L << dec_idx_s;

    // Handshake FSM; the decode of the live address is registered at accept so the
    // register pulse lands in the EXEC cycle and ack follows two edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            is_wr_r       <= 1'b0;
            err_r         <= 1'b0;
            mapped_r      <= 1'b0;
            idx_r         <= '0;
            cpu_ack       <= 1'b0;
            cpu_err       <= 1'b0;
            cpu_rd_data   <= '0;
            reg_wr_en     <= '0;
            reg_be        <= '0;
            reg_wr_data   <= '0;
            reg_rd_strobe <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    reg_wr_en     <= '0;
                    reg_rd_strobe <= '0;
                    if (cpu_req) begin
                        state_r     <= ST_EXEC;
                        is_wr_r     <= cpu_wr;
                        idx_r       <= dec_idx_s;
                        mapped_r    <= !bad_addr_s;
                        reg_be      <= cpu_be;
                        reg_wr_data <= cpu_wr_data;
                        if (cpu_wr) begin
                            err_r     <= bad_addr_s || dec_ro_s;
                            reg_wr_en <= (!bad_addr_s && !dec_ro_s && (cpu_be != '0))
                                         ? dec_onehot_s : '0;
                        end else begin
                            err_r         <= bad_addr_s;
                            reg_rd_strobe <= bad_addr_s ? '0 : dec_onehot_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    reg_wr_en     <= '0;
                    reg_rd_strobe <= '0;
                    state_r       <= ST_RESP;
                    if (!is_wr_r) begin
                        cpu_rd_data <= mapped_r ? reg_rd_data[int'(idx_r)*DATA_W +: DATA_W] : '0;
                    end
                end
                ST_RESP: begin
                    // First RESP cycle always raises ack, so a request dropped early still sees one ack.
                    if (!cpu_ack) begin
                        cpu_ack <= 1'b1;
                        cpu_err <= err_r;
                        state_r <= ST_RESP;
                    end else if (!cpu_req) begin
                        cpu_ack <= 1'b0;
                        cpu_err <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cpu_ack       <= 1'b0;
                    cpu_err       <= 1'b0;
                    reg_wr_en     <= '0;
                    reg_rd_strobe <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cpu_reg_bridge.sv
// Self-checking bench for sd_cpu_reg_bridge: a transaction-level reference model
// checked every cycle, plus directed transfers with hand-computed expectations.
module tb_sd_cpu_reg_bridge;
    import sd_reg_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [11:0]   cpu_addr = '0;
    logic [31:0]   cpu_wr_data = '0;
    logic [3:0]    cpu_be = '0;
    logic [31:0]   cpu_rd_data;
    logic          cpu_ack, cpu_err;
    logic [31:0]   reg_wr_en, reg_rd_strobe, reg_wr_data;
    logic [3:0]    reg_be;
    logic [1023:0] rd_bus;

    logic          p_req = 1'b0, p_wr = 1'b0;
    logic [11:0]   p_addr = '0;
    logic [15:0]   p_wd_in = '0, p_rd, p_wd;
    logic [1:0]    p_be_in = '0, p_be;
    logic          p_ack, p_err;
    logic [63:0]   p_wen, p_rstb;
    logic [1023:0] p_rd_bus;

    int n_cmp = 0, n_bad = 0;
    int wr_pulses = 0, rd_pulses = 0;
    logic [31:0] last_vec = '0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sd_cpu_reg_bridge #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(32), .BASE_ADDR(12'h000),
                        .RO_MASK(SD_RO_MASK_DEFAULT)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_be(cpu_be), .cpu_rd_data(cpu_rd_data), .cpu_ack(cpu_ack),
        .cpu_err(cpu_err), .reg_wr_en(reg_wr_en), .reg_be(reg_be), .reg_wr_data(reg_wr_data),
        .reg_rd_strobe(reg_rd_strobe), .reg_rd_data(rd_bus));

    sd_cpu_reg_bridge #(.DATA_W(16), .ADDR_W(12), .NUM_REGS(64), .BASE_ADDR(12'h100),
                        .RO_MASK(64'h0)) dut16 (
        .clk(clk), .rst_n(rst_n), .cpu_req(p_req), .cpu_wr(p_wr), .cpu_addr(p_addr),
        .cpu_wr_data(p_wd_in), .cpu_be(p_be_in), .cpu_rd_data(p_rd), .cpu_ack(p_ack),
        .cpu_err(p_err), .reg_wr_en(p_wen), .reg_be(p_be), .reg_wr_data(p_wd),
        .reg_rd_strobe(p_rstb), .reg_rd_data(p_rd_bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Address rules stated directly: window start, word alignment, slot count.
    function automatic int spec_slot(input int addr, input int base, input int bytes, input int nregs);
        int off;
        if (addr < base) return -1;
        off = addr - base;
        if (off % bytes != 0) return -1;
        if (off / bytes >= nregs) return -1;
        return off / bytes;
    endfunction

    function automatic bit is_ro(input int slot);
        return (slot == 9) || (slot == 12);  // 0x024 and 0x030
    endfunction

    // Reference model for the 32-bit instance: accept, pulse, capture, ack, release.
    bit          m_busy, m_wr, m_err;
    int          m_age, m_slot;
    logic [31:0] e_wen, e_rstb, e_rd, e_wd;
    logic [3:0]  e_be;
    logic        e_ack, e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_age <= 0; m_wr <= 1'b0; m_err <= 1'b0; m_slot <= -1;
            e_wen <= '0; e_rstb <= '0; e_rd <= '0; e_wd <= '0; e_be <= '0;
            e_ack <= 1'b0; e_err <= 1'b0;
        end else if (!m_busy) begin
            e_wen <= '0;
            e_rstb <= '0;
            if (cpu_req) begin
                int s;
                s = spec_slot(int'(cpu_addr), 0, 4, 32);
                m_busy <= 1'b1; m_age <= 0; m_wr <= cpu_wr; m_slot <= s;
                m_err  <= cpu_wr ? (s < 0 || is_ro(s)) : (s < 0);
                e_be <= cpu_be; e_wd <= cpu_wr_data;
                if (cpu_wr && s >= 0 && !is_ro(s) && cpu_be != 4'b0000) e_wen <= 32'd1 << s;
                if (!cpu_wr && s >= 0) e_rstb <= 32'd1 << s;
            end
        end else begin
            m_age <= m_age + 1;
            e_wen <= '0;
            e_rstb <= '0;
            if (m_age == 0 && !m_wr) e_rd <= (m_slot >= 0) ? rd_bus[m_slot*32 +: 32] : 32'h0;
            if (m_age == 1) begin e_ack <= 1'b1; e_err <= m_err; end
            if (m_age >= 2 && !cpu_req) begin e_ack <= 1'b0; e_err <= 1'b0; m_busy <= 1'b0; end
        end
    end

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", cpu_ack, e_ack);
            chk("err", cpu_err, e_err);
            chk("rd_data", cpu_rd_data, e_rd);
            chk("wr_en", reg_wr_en, e_wen);
            chk("rd_strobe", reg_rd_strobe, e_rstb);
            chk("pulse_excl", (|reg_wr_en) && (|reg_rd_strobe), 1'b0);
            if (e_wen != '0) begin
                chk("reg_be", reg_be, e_be);
                chk("reg_wr_data", reg_wr_data, e_wd);
            end
        end
        if (reg_wr_en != '0) begin wr_pulses++; last_vec = reg_wr_en; end
        if (reg_rd_strobe != '0) begin rd_pulses++; last_vec = reg_rd_strobe; end
    end

    task automatic xfer(input string nm, input logic wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input bit early,
                        input int hold, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_wp, input int exp_rp, input logic [31:0] exp_vec);
        int wp0, rp0, lat, acks;
        logic [1023:0] saved;
        wp0 = wr_pulses; rp0 = rd_pulses; lat = 0;
        cpu_wr = wr; cpu_addr = addr; cpu_wr_data = data; cpu_be = be; cpu_req = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (early && lat == 1) cpu_req = 1'b0;
        end while (!cpu_ack && lat < 20);
        chk({nm, " ack_latency"}, lat, 3);
        chk({nm, " err"}, cpu_err, exp_err);
        if (!wr) chk({nm, " rd_data"}, cpu_rd_data, exp_rd);
        acks = int'(cpu_ack);
        saved = rd_bus;
        for (int i = 1; i < hold && !early; i++) begin
            cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = 12'($urandom);
            cpu_wr_data = $urandom; cpu_be = 4'($urandom); rd_bus = ~rd_bus;
            @(negedge clk);
            acks += int'(cpu_ack);
        end
        cpu_req = 1'b0;
        rd_bus = saved;
        chk({nm, " ack_cycles"}, acks, early ? 1 : hold);
        @(negedge clk);
        chk({nm, " ack_release"}, cpu_ack, 1'b0);
        chk({nm, " wr_pulses"}, wr_pulses - wp0, exp_wp);
        chk({nm, " rd_pulses"}, rd_pulses - rp0, exp_rp);
        if (exp_wp + exp_rp > 0) chk({nm, " pulse_vec"}, last_vec, exp_vec);
    endtask

    task automatic xfer16(input string nm, input logic wr, input logic [11:0] addr,
                          input logic [15:0] data, input logic [1:0] be, input logic exp_err,
                          input logic [15:0] exp_rd, input logic [63:0] exp_vec);
        int lat, np;
        logic [63:0] vec;
        logic [1:0] gbe;
        logic [15:0] gwd;
        lat = 0; np = 0; vec = '0; gbe = '0; gwd = '0;
        p_wr = wr; p_addr = addr; p_wd_in = data; p_be_in = be; p_req = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (p_wen != '0 || p_rstb != '0) begin
                np++; vec = p_wen | p_rstb; gbe = p_be; gwd = p_wd;
            end
        end while (!p_ack && lat < 20);
        chk({nm, " ack_latency"}, lat, 3);
        chk({nm, " err"}, p_err, exp_err);
        chk({nm, " pulses"}, np, (exp_vec != '0) ? 1 : 0);
        chk({nm, " pulse_vec"}, vec, exp_vec);
        if (!wr) chk({nm, " rd_data"}, p_rd, exp_rd);
        if (wr && exp_vec != '0) begin
            chk({nm, " reg_be"}, gbe, be);
            chk({nm, " reg_wr_data"}, gwd, data);
        end
        p_req = 1'b0;
        @(negedge clk);
        chk({nm, " ack_release"}, p_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp0, lat;
        for (int i = 0; i < 32; i++) rd_bus[i*32 +: 32] = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
        rd_bus[12*32 +: 32] = 32'h1234_5678;
        for (int i = 0; i < 64; i++) p_rd_bus[i*16 +: 16] = 16'h1000 + 16'(i);

        repeat (3) @(negedge clk);
        chk("reset ack", cpu_ack, 1'b0);
        chk("reset rd_data", cpu_rd_data, 32'h0);
        chk("reset wr_en", reg_wr_en, 32'h0);
        chk("reset rd_strobe", reg_rd_strobe, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        //   name           wr    addr     data           be    early hold err  rd            wp rp vec
        xfer("wr_010",      1'b1, 12'h010, 32'hDEADBEEF, 4'h3, 1'b0, 1, 1'b0, 32'h0,        1, 0, 32'h0000_0010);
        xfer("rd_030",      1'b0, 12'h030, 32'h0,        4'h0, 1'b0, 3, 1'b0, 32'h1234_5678, 0, 1, 32'h0000_1000);
        xfer("rd_082_mis",  1'b0, 12'h082, 32'h0,        4'h0, 1'b0, 1, 1'b1, 32'h0,        0, 0, 32'h0);
        xfer("wr_200_unm",  1'b1, 12'h200, 32'h1111_2222, 4'hF, 1'b0, 1, 1'b1, 32'h0,       0, 0, 32'h0);
        xfer("wr_024_ro",   1'b1, 12'h024, 32'h3333_4444, 4'hF, 1'b0, 1, 1'b1, 32'h0,       0, 0, 32'h0);
        xfer("wr_008_be0",  1'b1, 12'h008, 32'h5555_6666, 4'h0, 1'b0, 1, 1'b0, 32'h0,       0, 0, 32'h0);
        xfer("wr_004_early",1'b1, 12'h004, 32'h0BAD_F00D, 4'hF, 1'b1, 1, 1'b0, 32'h0,       1, 0, 32'h0000_0002);
        xfer("wr_00C_hold", 1'b1, 12'h00C, 32'hCAFE_0001, 4'hC, 1'b0, 10, 1'b0, 32'h0,      1, 0, 32'h0000_0008);
        xfer("rd_054",      1'b0, 12'h054, 32'h0,        4'h0, 1'b0, 1, 1'b0, 32'hA000_1515, 0, 1, 32'h0020_0000);
        xfer("rd_07C_last", 1'b0, 12'h07C, 32'h0,        4'h0, 1'b0, 2, 1'b0, 32'hA000_1F1F, 0, 1, 32'h8000_0000);
        xfer("rd_080_end",  1'b0, 12'h080, 32'h0,        4'h0, 1'b0, 1, 1'b1, 32'h0,        0, 0, 32'h0);
        xfer("rd_030_again",1'b0, 12'h030, 32'h0,        4'h0, 1'b0, 1, 1'b0, 32'h1234_5678, 0, 1, 32'h0000_1000);

        // Reset asserted in the EXEC cycle of a write; request stays high across reset.
        cpu_wr = 1'b1; cpu_addr = 12'h010; cpu_wr_data = 32'h7777_8888; cpu_be = 4'hF; cpu_req = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid pre_pulse", reg_wr_en, 32'h0000_0010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid wr_en", reg_wr_en, 32'h0);
        chk("rst_mid ack", cpu_ack, 1'b0);
        chk("rst_mid rd_data", cpu_rd_data, 32'h0);
        chk("rst_mid reg_be", reg_be, 4'h0);
        chk("rst_mid reg_wr_data", reg_wr_data, 32'h0);
        repeat (2) @(negedge clk);
        wp0 = wr_pulses;
        rst_n = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 20);
        chk("rst_restart ack_latency", lat, 3);
        chk("rst_restart err", cpu_err, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_restart ack_release", cpu_ack, 1'b0);
        chk("rst_restart wr_pulses", wr_pulses - wp0, 1);

        xfer16("p16_wr_10E",  1'b1, 12'h10E, 16'hA5C3, 2'b10, 1'b0, 16'h0,    64'h0000_0000_0000_0080);
        xfer16("p16_rd_102",  1'b0, 12'h102, 16'h0,    2'b00, 1'b0, 16'h1001, 64'h0000_0000_0000_0002);
        xfer16("p16_rd_0FE",  1'b0, 12'h0FE, 16'h0,    2'b00, 1'b1, 16'h0,    64'h0);
        xfer16("p16_wr_17E",  1'b1, 12'h17E, 16'h5A5A, 2'b11, 1'b0, 16'h0,    64'h8000_0000_0000_0000);
        xfer16("p16_wr_180",  1'b1, 12'h180, 16'h1234, 2'b11, 1'b1, 16'h0,    64'h0);
        xfer16("p16_wr_10F",  1'b1, 12'h10F, 16'h4321, 2'b01, 1'b1, 16'h0,    64'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
